// File: rtl/line_segment_fetcher_pkg.sv
// Shared types and constants for the line segment fetcher: FSM encoding,
// default coordinate width and the position of each coordinate inside a ROM word.
package line_segment_fetcher_pkg;

    localparam int DEF_COORD_WIDTH = 13;
    localparam int FIELDS          = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Coordinate slots counted from the LSB of a ROM word, in units of COORD_WIDTH.
    localparam int SLOT_Y1 = 0;
    localparam int SLOT_X1 = 1;
    localparam int SLOT_Y0 = 2;
    localparam int SLOT_X0 = 3;

    function automatic int seg_width(input int coord_width);
        return FIELDS * coord_width;
    endfunction

    function automatic int field_lsb(input int slot, input int coord_width);
        return slot * coord_width;
    endfunction

endpackage

// File: rtl/line_segment_fetcher_seg_fifo2.sv
// Two-entry synchronous FIFO with a combinational head; simultaneous push and
// pop are both honoured, including when full.
module line_segment_fetcher_seg_fifo2 #(
    parameter int WIDTH = 52
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             do_pop;

    assign empty  = (count_reg == 2'd0);
    assign full   = (count_reg == 2'd2);
    assign count  = count_reg;
    assign dout   = mem_reg[rd_ptr_reg];
    assign do_pop = pop & ~empty;

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_reg[gi] <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                mem_reg[gi] <= din;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push)   wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop) rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/line_segment_fetcher.sv
// Walks the vertex ROM from address 0 to LAST_ADDR, absorbs its one-cycle read
// latency and hands each unpacked segment to the rasterizer over valid/ready.
module line_segment_fetcher
    import line_segment_fetcher_pkg::*;
#(
    parameter int COORD_WIDTH = DEF_COORD_WIDTH,
    parameter int ADDR_WIDTH  = 8,
    parameter int LAST_ADDR   = 255
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic [ADDR_WIDTH-1:0]               rom_addr,
    input  logic [seg_width(COORD_WIDTH)-1:0]   rom_q,
    output logic                                seg_valid,
    input  logic                                seg_ready,
    output logic [COORD_WIDTH-1:0]              x0,
    output logic [COORD_WIDTH-1:0]              y0,
    output logic [COORD_WIDTH-1:0]              x1,
    output logic [COORD_WIDTH-1:0]              y1,
    output logic                                busy,
    output logic                                done
);

    localparam int                    SEG_W = seg_width(COORD_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(LAST_ADDR);

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   rom_addr_reg;
    logic                    inflight_reg;
    logic                    issue;
    logic                    pop;
    logic                    at_last;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [1:0]              fifo_count;
    logic [SEG_W-1:0]        head;
    logic [COORD_WIDTH-1:0]  field [FIELDS];

    assign seg_valid = ~fifo_empty;
    assign pop       = seg_valid & seg_ready;
    assign at_last   = (rom_addr_reg == LAST);
    assign rom_addr  = rom_addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        busy       = (state_reg != ST_IDLE);
        done       = (state_reg == ST_DONE);
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // Only fetch when the word is guaranteed a FIFO slot on arrival.
                issue = ({1'b0, fifo_count} + {2'b00, inflight_reg}) < (3'd2 + {2'b00, pop});
                if (issue && at_last) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!inflight_reg && fifo_empty) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_reg <= '0;
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (state_reg == ST_DONE) begin
                rom_addr_reg <= '0;
            end else if (issue && !at_last) begin
                rom_addr_reg <= rom_addr_reg + 1'b1;
            end
        end
    end

    line_segment_fetcher_seg_fifo2 #(
        .WIDTH (SEG_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_reg),
        .pop   (pop),
        .din   (rom_q),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // The issue credit must make a push into a full, non-draining FIFO impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(inflight_reg && fifo_full && !pop));

    for (genvar gi = 0; gi < FIELDS; gi++) begin : g_unpack
        assign field[gi] = head[field_lsb(gi, COORD_WIDTH) +: COORD_WIDTH];
    end

    assign x0 = field[SLOT_X0];
    assign y0 = field[SLOT_Y0];
    assign x1 = field[SLOT_X1];
    assign y1 = field[SLOT_Y1];

endmodule

// File: tb/tb_line_segment_fetcher.sv
// Directed bench: three fetchers (LAST_ADDR 3, 255, 0) each fed by a one-cycle
// registered ROM model; a scoreboard queue holds the segments each pass must emit.
module tb_line_segment_fetcher;

    localparam int CW = 13;
    localparam int AW = 8;
    localparam int SW = 4 * CW;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_a     [NI];
    logic          seg_ready_a [NI];
    logic [AW-1:0] rom_addr_a  [NI];
    logic          seg_valid_a [NI];
    logic          busy_a      [NI];
    logic          done_a      [NI];
    logic [CW-1:0] x0_a [NI];
    logic [CW-1:0] y0_a [NI];
    logic [CW-1:0] x1_a [NI];
    logic [CW-1:0] y1_a [NI];
    logic [1:0]    occ_a [NI];

    function automatic int last_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 255 : 0);
    endfunction

    function automatic logic [SW-1:0] word_of(input logic [AW-1:0] a);
        logic [CW-1:0] i;
        i = CW'(a);
        return {i + 13'd1, i + 13'd2, i + 13'd3, i + 13'd4};
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int LA = (gi == 0) ? 3 : ((gi == 1) ? 255 : 0);
        logic [SW-1:0] rom_q;
        always @(posedge clk) rom_q <= word_of(rom_addr_a[gi]);

        line_segment_fetcher #(
            .COORD_WIDTH (CW),
            .ADDR_WIDTH  (AW),
            .LAST_ADDR   (LA)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_a[gi]),
            .rom_addr  (rom_addr_a[gi]),
            .rom_q     (rom_q),
            .seg_valid (seg_valid_a[gi]),
            .seg_ready (seg_ready_a[gi]),
            .x0        (x0_a[gi]),
            .y0        (y0_a[gi]),
            .x1        (x1_a[gi]),
            .y1        (y1_a[gi]),
            .busy      (busy_a[gi]),
            .done      (done_a[gi])
        );

        assign occ_a[gi] = u_dut.u_fifo.count_reg;
    end

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            n_xfer, done_cnt, start_cyc;
    int            first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc;
    bit            stall_held;
    logic [SW-1:0] held_word;
    logic [SW-1:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe one cycle of instance k (values seen now are what the next edge samples).
    task automatic step(input int k);
        logic [SW-1:0] w;
        logic [SW-1:0] e;
        w = {x0_a[k], y0_a[k], x1_a[k], y1_a[k]};
        if (stall_held) begin
            chk("stall_valid", 64'(seg_valid_a[k]), 64'd1);
            chk("stall_data", 64'(w), 64'(held_word));
        end
        if (seg_valid_a[k] && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (seg_valid_a[k] && seg_ready_a[k]) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL extra_segment observed=%0h expected=none", w);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("seg_data", 64'(w), 64'(e));
            end
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            n_xfer++;
        end
        if (done_a[k]) begin
            done_cnt++;
            done_cyc = cyc;
        end
        checks++;
        assert (occ_a[k] <= 2'd2) else begin
            failures++;
            $error("FAIL fifo_occupancy observed=%0d expected<=2", occ_a[k]);
        end
        stall_held = seg_valid_a[k] && !seg_ready_a[k];
        held_word  = w;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_pass(input int k);
        n_xfer = 0; done_cnt = 0; stall_held = 1'b0;
        first_valid_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
        sb.delete();
        for (int i = 0; i <= last_of(k); i++) sb.push_back(word_of(AW'(i)));
        start_cyc  = cyc;
        start_a[k] = 1'b1;
        step(k);
        start_a[k] = 1'b0;
    endtask

    task automatic finish_pass(input int k, input int budget, input bit rand_ready);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            if (rand_ready) seg_ready_a[k] = 1'($urandom_range(0, 1));
            step(k);
            n++;
        end
        chk("done_seen", 64'(done_cnt), 64'd1);
        seg_ready_a[k] = 1'b1;
        for (int i = 0; i < 3; i++) step(k);
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("seg_count", 64'(n_xfer), 64'(last_of(k) + 1));
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("idle_busy", 64'(busy_a[k]), 64'd0);
        chk("idle_addr", 64'(rom_addr_a[k]), 64'd0);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            start_a[k]     = 1'b0;
            seg_ready_a[k] = 1'b1;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_valid", 64'(seg_valid_a[k]), 64'd0);
            chk("rst_busy", 64'(busy_a[k]), 64'd0);
            chk("rst_done", 64'(done_a[k]), 64'd0);
        end
        chk("rst_coords", 64'({x0_a[0], y0_a[0], x1_a[0], y1_a[0]}), 64'd0);
        chk("rst_addr", 64'(rom_addr_a[1]), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Short pass with ready high: latency, field unpack, back-to-back segments, done timing.
        begin_pass(0);
        chk("t1_valid_e1", 64'(seg_valid_a[0]), 64'd0);
        chk("t1_busy", 64'(busy_a[0]), 64'd1);
        step(0);
        chk("t1_valid_e2", 64'(seg_valid_a[0]), 64'd0);
        step(0);
        chk("t1_valid_e3", 64'(seg_valid_a[0]), 64'd1);
        chk("t2_x0", 64'(x0_a[0]), 64'd1);
        chk("t2_y0", 64'(y0_a[0]), 64'd2);
        chk("t2_x1", 64'(x1_a[0]), 64'd3);
        chk("t2_y1", 64'(y1_a[0]), 64'd4);
        finish_pass(0, 50, 1'b0);
        chk("t1_first_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
        chk("t1_back_to_back", 64'(last_xfer_cyc - first_xfer_cyc), 64'd3);
        chk("t1_done_after_last", 64'(done_cyc - last_xfer_cyc), 64'd2);

        // Full pass under random back-pressure.
        seg_ready_a[1] = 1'b0;
        begin_pass(1);
        finish_pass(1, 3000, 1'b1);

        // Ready held low: exactly two words buffered, address parked, then resume.
        seg_ready_a[1] = 1'b0;
        begin_pass(1);
        for (int i = 0; i < 20; i++) step(1);
        chk("t4_occ", 64'(occ_a[1]), 64'd2);
        chk("t4_addr", 64'(rom_addr_a[1]), 64'd2);
        chk("t4_valid", 64'(seg_valid_a[1]), 64'd1);
        chk("t4_no_xfer", 64'(n_xfer), 64'd0);
        seg_ready_a[1] = 1'b1;
        finish_pass(1, 600, 1'b0);

        // Reset mid-pass after five transfers, then restart from address 0.
        seg_ready_a[1] = 1'b1;
        begin_pass(1);
        for (int i = 0; i < 20 && n_xfer < 5; i++) step(1);
        chk("t5_xfers", 64'(n_xfer), 64'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid", 64'(seg_valid_a[1]), 64'd0);
        chk("t5_busy", 64'(busy_a[1]), 64'd0);
        chk("t5_done", 64'(done_a[1]), 64'd0);
        chk("t5_coords", 64'({x0_a[1], y0_a[1], x1_a[1], y1_a[1]}), 64'd0);
        chk("t5_addr", 64'(rom_addr_a[1]), 64'd0);
        chk("t5_occ", 64'(occ_a[1]), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        cyc++;
        begin_pass(1);
        finish_pass(1, 600, 1'b0);

        // LAST_ADDR=0 with a second start while busy: one segment only.
        begin_pass(2);
        chk("t6_busy", 64'(busy_a[2]), 64'd1);
        start_a[2] = 1'b1;
        step(2);
        start_a[2] = 1'b0;
        finish_pass(2, 50, 1'b0);
        for (int i = 0; i < 4; i++) step(2);
        chk("t6_no_rerun", 64'(n_xfer), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
